axis_rr_pkt_arbiter: RTL and testbench

- Shares one AXI4-Stream egress (64-bit data, 8-bit keep, last) between NUM_IN stream requesters, one whole packet at a time.
- Arbitration is round-robin. A grant is held from the first beat until the tlast beat is accepted, so packets never interleave.
- Sits in front of the shell's single stream sink (network TX or file/log sink); drives the source index as a tag alongside the data.

---
 rtl/axis_arb_pkg.sv | 35 +++
 rtl/axis_rr_pkt_arbiter_rr_arbiter.sv | 21 ++
 rtl/axis_rr_pkt_arbiter.sv | 74 +++++++
 tb/tb_axis_rr_pkt_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types, default widths and the round-robin pick
// function used by the packet arbiter.
package axis_arb_pkg;

    typedef enum logic {IDLE, PASS} state_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int MAX_IN         = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scan from last+1 upward with wrap. Walking k downward lets the
    // nearest requester overwrite any farther one.
    function automatic pick_t rr_pick(input logic [MAX_IN-1:0] req, input logic [3:0] last,
                                      input int n);
        pick_t p;
        int    c;
        p = '0;
        for (int k = MAX_IN; k >= 1; k--) begin
            if (k <= n) begin
                c = (int'(last) + k) % n;
                if (req[c]) begin
                    p.found = 1'b1;
                    p.idx   = 4'(c);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin select; the winner is the first
// requester found after the previous grant, wrapping around.
module rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    pick_t p;

    assign p     = rr_pick(MAX_IN'(req), 4'(last), NUM_IN);
    assign found = p.found;
    assign idx   = IDX_W'(p.idx);

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// axis_rr_pkt_arbiter: packet-granular round-robin AXI4-Stream arbiter;
// a grant is held from the first beat until the tlast beat is accepted.
module axis_rr_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_IN*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_IN-1:0]            s_axis_tlast,
    input  logic [NUM_IN-1:0]            s_axis_tvalid,
    output logic [NUM_IN-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [IDX_W-1:0]             m_axis_tid,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         pkt_count
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant, last_grant, pick;
    logic             found, done;

    rr_arbiter #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_rr (
        .req  (s_axis_tvalid),
        .last (last_grant),
        .found(found),
        .idx  (pick)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_IN - 1);
            pkt_count  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (done)
                pkt_count <= pkt_count + 1'b1;
        end
    end

    always_comb
        state_nxt = (state == IDLE) ? (found ? PASS : IDLE) : (done ? IDLE : PASS);

    // Pure pass-through while PASS; the bus is forced quiet otherwise.
    always_comb begin
        busy          = (state == PASS);
        m_axis_tdata  = busy ? s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
        m_axis_tkeep  = busy ? s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
        m_axis_tlast  = busy ? s_axis_tlast[grant] : 1'b0;
        m_axis_tvalid = busy ? s_axis_tvalid[grant] : 1'b0;
        m_axis_tid    = grant;
        s_axis_tready = '0;
        if (busy)
            s_axis_tready[grant] = m_axis_tready;
        done = busy && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// tb_axis_rr_pkt_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a packet-level round-robin reference model.
module tb_axis_rr_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*KW-1:0] s_tkeep = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast, m_tvalid;
    logic            m_tready = 1'b0;
    logic [IW-1:0]   m_tid;
    logic            busy;
    logic [CW-1:0]   pkt_count;

    always #5 clk = ~clk;

    axis_rr_pkt_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tid   (m_tid),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    int vectors = 0, miscompares = 0;
    int len[N], pos[N], seq[N], gap[N];
    bit en[N], vld[N];
    int pv, rmode, fixlen, gap_src, cyc;
    int owner, lastg, cnt;
    int firsts[$];

    function automatic logic [DW-1:0] beat_data(int i);
        return {24'hA5C3E1, 8'(i), 16'(seq[i]), 16'(pos[i])};
    endfunction

    function automatic logic [KW-1:0] beat_keep(int i);
        return 8'(seq[i] * 37 + pos[i] * 5 + i);
    endfunction

    function automatic int new_len();
        return fixlen > 0 ? fixlen : int'($urandom_range(1, 4));
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = vld[i];
            s_tdata[i*DW +: DW]  = beat_data(i);
            s_tkeep[i*KW +: KW]  = beat_keep(i);
            s_tlast[i]           = (pos[i] == len[i] - 1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++)
            if (!vld[i] && en[i]) begin
                if (gap[i] > 0) gap[i]--;
                else vld[i] = (int'($urandom_range(0, 99)) < pv);
            end
        m_tready = (rmode == 0) || (rmode == 1 && $urandom_range(0, 3) != 0) ||
                   (rmode == 2 && (cyc % 4 == 0 || cyc % 4 == 3));
        apply();
    endtask

    task automatic compare();
        logic [N-1:0] er;
        er = '0;
        if (owner >= 0) er[owner] = m_tready;
        chk("s_tready", s_tready, er);
        chk("busy", busy, owner >= 0);
        chk("pkt_count", pkt_count, cnt);
        if (owner >= 0) begin
            chk("m_tvalid", m_tvalid, vld[owner]);
            chk("m_tid", m_tid, owner);
            chk("m_tdata", m_tdata, beat_data(owner));
            chk("m_tkeep", m_tkeep, beat_keep(owner));
            chk("m_tlast", m_tlast, pos[owner] == len[owner] - 1);
        end else begin
            chk("idle_tvalid", m_tvalid, 0);
            chk("idle_tdata", m_tdata, 0);
            chk("idle_keep_last", {m_tkeep, m_tlast}, 0);
        end
    endtask

    task automatic step();
        int acc;
        bit lb;
        logic [N-1:0] tv;
        logic mr;
        drive();
        #1;
        compare();
        if (m_tvalid && m_tready && !$isunknown(m_tid) && pos[m_tid] == 0)
            firsts.push_back(int'(m_tid));
        tv  = s_tvalid;
        mr  = m_tready;
        acc = -1;
        @(posedge clk);
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (lastg + k) % N;
                if (tv[c]) begin
                    owner = c;
                    lastg = c;
                    break;
                end
            end
        end else if (tv[owner] && mr) begin
            acc = owner;
            if (pos[owner] == len[owner] - 1) begin
                owner = -1;
                cnt   = (cnt + 1) % (1 << CW);
            end
        end
        if (acc >= 0) begin
            vld[acc] = 0;
            lb = (pos[acc] == len[acc] - 1);
            if (lb) begin
                pos[acc] = 0;
                seq[acc]++;
                len[acc] = new_len();
            end else pos[acc]++;
            if (acc == gap_src && pos[acc] == 1) gap[acc] = 4;
            else if (rmode == 1) gap[acc] = int'($urandom_range(0, 3)) == 0 ? 2 : 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cfg(bit [N-1:0] e, int p, int r, int fl);
        for (int i = 0; i < N; i++) en[i] = e[i];
        pv      = p;
        rmode   = r;
        fixlen  = fl;
        gap_src = -1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_tid", m_tid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", pkt_count, 0);
        for (int i = 0; i < N; i++) begin
            vld[i] = 0;
            pos[i] = 0;
            gap[i] = 0;
            len[i] = new_len();
        end
        apply();
        owner = -1;
        lastg = N - 1;
        cnt   = 0;
        cyc   = 0;
        firsts.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        @(negedge clk);

        // Single 3-beat packet from input 2.
        cfg(4'b0100, 100, 0, 3);
        do_reset();
        repeat (4) step();
        chk("p1_count", pkt_count, 1);
        chk("p1_busy", busy, 0);

        // All inputs streaming 2-beat packets: strict 0,1,2,3,0 order.
        cfg(4'b1111, 100, 0, 2);
        do_reset();
        repeat (15) step();
        chk("p2_count", pkt_count, 5);
        chk("p2_npkts", firsts.size(), 5);
        for (int k = 0; k < 5 && k < firsts.size(); k++) chk("p2_order", firsts[k], k % 4);

        // Input 1 stalls mid-packet while input 3 waits.
        cfg(4'b1010, 100, 0, 3);
        gap_src = 1;
        do_reset();
        repeat (12) step();
        chk("p3_npkts_ge2", firsts.size() >= 2, 1);
        if (firsts.size() >= 2) begin
            chk("p3_first", firsts[0], 1);
            chk("p3_second", firsts[1], 3);
        end

        // Egress ready pattern 1,0,0,1 during a 4-beat packet.
        cfg(4'b0100, 100, 2, 4);
        do_reset();
        repeat (12) step();
        chk("p4_count", pkt_count, 1);

        // Reset in beat 2 of a 4-beat packet, then 0 vs 3 contention.
        cfg(4'b0100, 100, 0, 4);
        do_reset();
        for (int t = 0; t < 10 && !(owner == 2 && pos[2] == 1); t++) step();
        drive();
        #1;
        chk("p5_mid_valid", m_tvalid, 1);
        cfg(4'b1001, 100, 0, 2);
        do_reset();
        repeat (3) step();
        chk("p5_npkts", firsts.size() >= 1, 1);
        if (firsts.size() >= 1) chk("p5_winner", firsts[0], 0);

        // Counter wrap with single-beat packets.
        cfg(4'b0010, 100, 0, 1);
        do_reset();
        repeat (30) step();
        chk("p6_count15", pkt_count, 15);
        repeat (2) step();
        chk("p6_wrap", pkt_count, 0);

        // Random traffic, lengths, gaps and backpressure.
        cfg(4'b1111, 60, 1, 0);
        do_reset();
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
